// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared types and sizes for the 4-way round-robin mux arbiter
package mux4_arb_pkg;
  localparam int NUM_REQ = 4;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef logic [1:0] owner_t;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: first set request bit scanning upward (mod 4) from start
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  owner_t             start,
  output logic               found,
  output owner_t             idx
);
  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[start + owner_t'(k)]) begin
        found = 1'b1;
        idx   = start + owner_t'(k);
      end
    end
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 mux; define GRANT_TIMEOUT_EN
// to preempt an owner after HOLD_MAX consecutive cycles when others are waiting.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DW       = 3,
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DW-1:0]      i0,
  input  logic [DW-1:0]      i1,
  input  logic [DW-1:0]      i2,
  input  logic [DW-1:0]      i3,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s1,
  output logic               s0,
  output logic [DW-1:0]      y,
  output logic               y_valid
);
  arb_state_t state, state_n;
  owner_t     sel, last_owner, idx;
  logic       found, keep, take, expire;
  rr_pick4 u_pick (
    .req  (req),
    .start(last_owner + owner_t'(1)),
    .found(found),
    .idx  (idx)
  );
`ifdef GRANT_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt;
  assign expire = (cnt == CW'(HOLD_MAX)) && |(req & ~gnt);
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (take) cnt <= CW'(1);
    else if (keep && cnt != CW'(HOLD_MAX)) cnt <= cnt + CW'(1);
  end
`else
  assign expire = 1'b0;
`endif
  // last_owner equals sel after any grant; it differs only out of reset so 0 wins first
  always_comb begin
    keep    = (state == GRANT) && req[sel] && !expire;
    take    = !keep && found;
    state_n = (keep || take) ? GRANT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= '0;
      sel        <= 2'd0;
      last_owner <= 2'd3;
    end else if (take) begin
      gnt        <= 4'b0001 << idx;
      sel        <= idx;
      last_owner <= idx;
    end else if (!keep) begin
      gnt <= '0;
    end
  end
  assign s1      = sel[1];
  assign s0      = sel[0];
  assign y_valid = (state == GRANT);
  assign y       = !y_valid ? '0 : sel[1] ? (sel[0] ? i3 : i2) : (sel[0] ? i1 : i0);
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed plus random stimulus against a behavioural arbiter model
module tb_mux4_rr_arbiter;
  localparam int DW = 3;
  localparam int HOLD = 4;
`ifdef GRANT_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, gnt;
  logic [DW-1:0] i0 = '0, i1 = '0, i2 = '0, i3 = '0, y;
  logic s1, s0, y_valid;
  int errors = 0, checks = 0;
  bit m_gr = 1'b0;
  int m_own = 0, m_last = 3, m_cnt = 0;

  mux4_rr_arbiter #(.DW(DW), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .gnt(gnt), .s1(s1), .s0(s0), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] q, input int start);
    for (int k = 0; k < 4; k++)
      if (q[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  function automatic logic [DW-1:0] data_of(input int k);
    return k == 0 ? i0 : k == 1 ? i1 : k == 2 ? i2 : i3;
  endfunction

  // advance the model by one clock edge using the inputs driven before it
  task automatic model_edge();
    bit others, stay;
    int p;
    if (rst) begin
      m_gr = 1'b0; m_own = 0; m_last = 3; m_cnt = 0;
      return;
    end
    others = (req & ~(4'b0001 << m_own)) != 0;
    stay = m_gr && req[m_own] && !(TO && m_cnt == HOLD && others);
    if (stay) begin
      if (m_cnt < HOLD) m_cnt++;
    end else begin
      p = pick(req, (m_last + 1) % 4);
      if (p >= 0) begin
        m_gr = 1'b1; m_own = p; m_last = p; m_cnt = 1;
      end else m_gr = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt", gnt, m_gr ? 8'(4'b0001 << m_own) : 8'h0);
    chk("sel", {s1, s0}, 8'(m_own));
    chk("y_valid", y_valid, m_gr);
    chk("y", y, m_gr ? data_of(m_own) : '0);
    chk("onehot", $onehot0(gnt), 1'b1);
  endtask

  task automatic rand_data();
    i0 = DW'($urandom); i1 = DW'($urandom); i2 = DW'($urandom); i3 = DW'($urandom);
  endtask

  initial begin
    i0 = 3'd1; i1 = 3'd2; i2 = 3'd5; i3 = 3'd7;
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1111);
    chk("reset_gnt", gnt, 8'h0);
    step(1'b0, 4'b1111);
    chk("first_gnt", gnt, 8'b0001);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0100);
    chk("single_gnt", gnt, 8'b0100);
    chk("single_y", y, 8'd5);
    step(1'b0, 4'b0000);
    chk("single_drop", y_valid, 1'b0);
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1111);
    step(1'b0, 4'b1110);
    chk("rot_1", gnt, 8'b0010);
    step(1'b0, 4'b1101);
    chk("rot_2", gnt, 8'b0100);
    step(1'b0, 4'b1011);
    chk("rot_3", gnt, 8'b1000);
    step(1'b0, 4'b0111);
    chk("rot_0", gnt, 8'b0001);
    step(1'b0, 4'b1110);
    for (int c = 0; c < 10; c++) begin
      i1 = DW'(c);
      step(1'b0, 4'b1111);
    end
    step(1'b1, 4'b0000);
    for (int c = 0; c < 12; c++) step(1'b0, 4'b0011);
    for (int c = 0; c < 8; c++) step(1'b0, 4'b0001);
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1000);
    chk("pre_rst_gnt", gnt, 8'b1000);
    step(1'b1, 4'b1000);
    chk("mid_rst_gnt", gnt, 8'h0);
    step(1'b0, 4'b1001);
    chk("post_rst_gnt", gnt, 8'b0001);
    for (int c = 0; c < 400; c++) begin
      rand_data();
      step($urandom_range(0, 49) == 0, ($urandom_range(0, 3) == 0) ? 4'($urandom) : (req | 4'($urandom & $urandom)) & ~4'($urandom & $urandom & $urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
